// File: rtl/ga_pkg.sv
// Shared constants and types for the gate-array sync and interrupt stage.
// Holds the GA command decode, 52-line counter limits and the mode type.
package ga_pkg;

    localparam logic [1:0] GA_CMD_MODE    = 2'b10;
    localparam int         GA_INT_RST_BIT = 4;

    localparam logic [5:0] R52_WRAP        = 6'd52;
    localparam logic [5:0] R52_SYNC_THRESH = 6'd32;

    typedef logic [1:0] MODE_T;

endpackage

// File: rtl/ga_sync_shaper.sv
// One sync channel: edge-samples a CRTC sync on CE, counts events while the
// sync is high and emits a delayed, width-limited registered monitor sync.
// Ports: CLOCK, RESET, ce (character enable), sync_in (raw CRTC sync),
//        tick (count event, already CE-qualified), rise/fall (edge strobes,
//        CE-qualified), mon (shaped monitor sync).
module ga_sync_shaper #(
    parameter int DELAY = 2,
    parameter int WIDTH = 4
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic ce,
    input  logic sync_in,
    input  logic tick,
    output logic rise,
    output logic fall,
    output logic mon
);

    localparam logic [3:0] WIN_LO = 4'(DELAY);
    localparam logic [3:0] WIN_HI = 4'(DELAY + WIDTH);

    logic       prev;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    assign rise = ce & sync_in & ~prev;
    assign fall = ce & ~sync_in & prev;

    // The rising edge restarts the count; otherwise count while high and
    // park at 15 so a long sync never wraps back into the window.
    always_comb begin
        cnt_nxt = cnt;
        if (rise) begin
            cnt_nxt = 4'd0;
        end else if (tick && sync_in && (cnt != 4'hF)) begin
            cnt_nxt = cnt + 4'd1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            prev <= 1'b0;
            cnt  <= 4'd0;
            mon  <= 1'b0;
        end else if (ce) begin
            prev <= sync_in;
            cnt  <= cnt_nxt;
            mon  <= sync_in & (cnt_nxt >= WIN_LO) & (cnt_nxt < WIN_HI);
        end
    end

endmodule

// File: rtl/ga_sync_irq.sv
// Gate-array sync/interrupt stage behind the 6845: raster interrupt counter,
// monitor HSYNC/VSYNC shaping and the line-start screen mode latch.
// Ports: CLOCK, RESET (sync, active high), CE_1M, CRTC_HSYNC, CRTC_VSYNC,
//        GA_WR/GA_DI (GA write), INT_ACK -> INT, MON_HSYNC, MON_VSYNC,
//        MODE, R52 (line counter).
import ga_pkg::*;

module ga_sync_irq #(
    parameter int HS_DELAY = 2,
    parameter int HS_WIDTH = 4,
    parameter int VS_DELAY = 2,
    parameter int VS_WIDTH = 4
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       CE_1M,
    input  logic       CRTC_HSYNC,
    input  logic       CRTC_VSYNC,
    input  logic       GA_WR,
    input  logic [7:0] GA_DI,
    input  logic       INT_ACK,
    output logic       INT,
    output logic       MON_HSYNC,
    output logic       MON_VSYNC,
    output logic [1:0] MODE,
    output logic [5:0] R52
);

    localparam logic [1:0] VDLY_INIT = 2'(VS_DELAY);

    logic       hs_rise;
    logic       hs_fall;
    logic       vs_rise;
    logic       vs_fall;
    logic       cmd;
    logic       int_clr;
    logic       expire;
    logic       irq_set;
    logic       int_nxt;
    logic [1:0] vdly;
    logic [5:0] r52_inc;
    logic [5:0] r52_nxt;
    MODE_T      pend_mode;
    logic       unused_ok;

    ga_sync_shaper #(
        .DELAY (HS_DELAY),
        .WIDTH (HS_WIDTH)
    ) u_hs (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .ce      (CE_1M),
        .sync_in (CRTC_HSYNC),
        .tick    (CE_1M),
        .rise    (hs_rise),
        .fall    (hs_fall),
        .mon     (MON_HSYNC)
    );

    ga_sync_shaper #(
        .DELAY (VS_DELAY),
        .WIDTH (VS_WIDTH)
    ) u_vs (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .ce      (CE_1M),
        .sync_in (CRTC_VSYNC),
        .tick    (hs_fall),
        .rise    (vs_rise),
        .fall    (vs_fall),
        .mon     (MON_VSYNC)
    );

    assign unused_ok = ^{GA_DI[5], GA_DI[3:2], vs_fall};

    assign cmd     = GA_WR & (GA_DI[7:6] == GA_CMD_MODE);
    assign int_clr = cmd & GA_DI[GA_INT_RST_BIT];
    assign expire  = hs_fall & (vdly == 2'd1);
    assign r52_inc = R52 + 6'd1;

    always_comb begin
        r52_nxt = R52;
        irq_set = 1'b0;
        if (hs_fall) begin
            if (expire) begin
                r52_nxt = 6'd0;
                irq_set = (R52 >= R52_SYNC_THRESH);
            end else if (r52_inc == R52_WRAP) begin
                r52_nxt = 6'd0;
                irq_set = 1'b1;
            end else begin
                r52_nxt = r52_inc;
            end
        end
        // Ack loses to a same-cycle set but still strips bit 5.
        if (INT_ACK) begin
            r52_nxt[5] = 1'b0;
        end
        int_nxt = irq_set ? 1'b1 : (INT_ACK ? 1'b0 : INT);
        if (int_clr) begin
            r52_nxt = 6'd0;
            int_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            vdly <= 2'd0;
        end else if (vs_rise) begin
            vdly <= VDLY_INIT;
        end else if (hs_fall && (vdly != 2'd0)) begin
            vdly <= vdly - 2'd1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            R52       <= 6'd0;
            INT       <= 1'b0;
            pend_mode <= 2'd0;
            MODE      <= 2'd0;
        end else begin
            R52 <= r52_nxt;
            INT <= int_nxt;
            if (cmd) begin
                pend_mode <= GA_DI[1:0];
            end
            // A write landing on the line start goes straight to MODE.
            if (hs_rise) begin
                MODE <= cmd ? GA_DI[1:0] : pend_mode;
            end
        end
    end

endmodule

// File: tb/tb_ga_sync_irq.sv
// Scoreboard bench for ga_sync_irq: directed raster scenarios plus random
// lines, each cycle checked against a behavioural model of the stage.
module tb_ga_sync_irq;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       CE_1M;
    logic       CRTC_HSYNC;
    logic       CRTC_VSYNC;
    logic       GA_WR;
    logic [7:0] GA_DI;
    logic       INT_ACK;
    logic       INT;
    logic       MON_HSYNC;
    logic       MON_VSYNC;
    logic [1:0] MODE;
    logic [5:0] R52;

    always #5 CLOCK = ~CLOCK;

    ga_sync_irq dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .CE_1M      (CE_1M),
        .CRTC_HSYNC (CRTC_HSYNC),
        .CRTC_VSYNC (CRTC_VSYNC),
        .GA_WR      (GA_WR),
        .GA_DI      (GA_DI),
        .INT_ACK    (INT_ACK),
        .INT        (INT),
        .MON_HSYNC  (MON_HSYNC),
        .MON_VSYNC  (MON_VSYNC),
        .MODE       (MODE),
        .R52        (R52)
    );

    typedef struct packed {
        logic       irq;
        logic       mh;
        logic       mv;
        logic [1:0] mode;
        logic [5:0] r52;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: line count, ticks since HSYNC start, falls since
    // VSYNC start, falls left until re-sync.
    bit m_ph, m_pv, m_irq, m_mh, m_mv;
    int m_r52, m_mode, m_pend, m_vdly, m_ht, m_vf;

    function automatic void model(bit rst, bit ce, bit hs, bit vs,
                                  bit wr, logic [7:0] di, bit ack);
        bit rise, fall, vr, cmd, expire, set;
        if (rst) begin
            m_ph = 0; m_pv = 0; m_irq = 0; m_mh = 0; m_mv = 0;
            m_r52 = 0; m_mode = 0; m_pend = 0; m_vdly = 0;
            m_ht = 0; m_vf = 0;
            return;
        end
        rise = ce && hs && !m_ph;
        fall = ce && !hs && m_ph;
        vr   = ce && vs && !m_pv;
        cmd  = wr && (di[7:6] == 2'b10);
        if (rise) m_mode = cmd ? int'(di[1:0]) : m_pend;
        if (cmd) m_pend = int'(di[1:0]);
        expire = fall && (m_vdly == 1);
        if (vr) m_vdly = 2;
        else if (fall && m_vdly > 0) m_vdly--;
        set = 0;
        if (fall) begin
            if (expire) begin
                set = (m_r52 >= 32);
                m_r52 = 0;
            end else begin
                m_r52 = (m_r52 + 1) % 52;
                set = (m_r52 == 0);
            end
        end
        if (set) m_irq = 1;
        else if (ack) m_irq = 0;
        if (ack) m_r52 = m_r52 % 32;
        if (cmd && di[4]) begin
            m_r52 = 0;
            m_irq = 0;
        end
        if (ce) begin
            if (rise) m_ht = 0;
            else if (hs && m_ht < 1000) m_ht++;
            if (vr) m_vf = 0;
            else if (fall && vs && m_vf < 1000) m_vf++;
            m_mh = hs && (m_ht >= 2) && (m_ht < 6);
            m_mv = vs && (m_vf >= 2) && (m_vf < 6);
            m_ph = hs;
            m_pv = vs;
        end
    endfunction

    // One clock: drive inputs, push the model's post-edge outputs, and
    // return #1 after the following negedge.
    task automatic clk1(bit rst, bit ce, bit hs, bit vs,
                        bit wr, logic [7:0] di, bit ack);
        exp_t e;
        RESET      = rst;
        CE_1M      = ce;
        CRTC_HSYNC = hs;
        CRTC_VSYNC = vs;
        GA_WR      = wr;
        GA_DI      = di;
        INT_ACK    = ack;
        model(rst, ce, hs, vs, wr, di, ack);
        e.irq  = m_irq;
        e.mh   = m_mh;
        e.mv   = m_mv;
        e.mode = 2'(m_mode);
        e.r52  = 6'(m_r52);
        sbq.push_back(e);
        @(posedge CLOCK);
        @(negedge CLOCK);
        #1;
    endtask

    always @(negedge CLOCK) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if ({INT, MON_HSYNC, MON_VSYNC, MODE, R52} !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t got int=%0b mh=%0b mv=%0b mode=%0d r52=%0d exp int=%0b mh=%0b mv=%0b mode=%0d r52=%0d",
                         $time, INT, MON_HSYNC, MON_VSYNC, MODE, R52,
                         e.irq, e.mh, e.mv, e.mode, e.r52);
            end
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    logic [63:0] mh_cap;
    bit          vs_lvl;
    bit          side_rnd;

    // One raster line of CE ticks; HSYNC high for the first `width` ticks.
    // An optional write/ack lands on the CE cycle of tick ev_t.
    task automatic line(int period, int width, int ev_t, bit ev_wr,
                        logic [7:0] ev_di, bit ev_ack, int gap_max);
        for (int t = 0; t < period; t++) begin
            bit hs, ew, ea;
            hs = (t < width);
            ew = ev_wr && (t == ev_t);
            ea = ev_ack && (t == ev_t);
            clk1(0, 1, hs, vs_lvl, ew, ev_di, ea);
            if (t < 64) mh_cap[t] = MON_HSYNC;
            repeat ($urandom_range(gap_max, 0)) begin
                bit sw, sa;
                sw = side_rnd && ($urandom % 16 == 0);
                sa = side_rnd && ($urandom % 16 == 0);
                clk1(0, 0, hs, vs_lvl, sw, 8'($urandom), sa);
            end
        end
    endtask

    task automatic lines(int n);
        for (int i = 0; i < n; i++) line(64, 14, -1, 0, 8'h00, 0, 1);
    endtask

    task automatic idle(bit wr, logic [7:0] di, bit ack);
        clk1(0, 0, 0, vs_lvl, wr, di, ack);
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] mv_cap;
        vs_lvl   = 0;
        side_rnd = 0;
        mh_cap   = '0;
        RESET = 1; CE_1M = 0; CRTC_HSYNC = 0; CRTC_VSYNC = 0;
        GA_WR = 0; GA_DI = 0; INT_ACK = 0;
        @(negedge CLOCK);
        #1;
        repeat (3) clk1(1, 0, 0, 0, 0, 8'h00, 0);
        chk("reset_outputs", {INT, MON_HSYNC, MON_VSYNC, MODE, R52}, 0);

        lines(51);
        chk("r52_before_wrap", R52, 51);
        chk("int_before_wrap", INT, 0);
        chk("mon_hs_width14", mh_cap[15:0], 16'h003C);
        lines(1);
        chk("wrap_int", INT, 1);
        chk("wrap_r52", R52, 0);
        lines(3);
        chk("int_holds", INT, 1);
        idle(0, 8'h00, 1);
        chk("ack_int", INT, 0);
        chk("ack_r52_kept", R52, 3);

        lines(34);
        chk("r52_37", R52, 37);
        idle(0, 8'h00, 1);
        chk("ack_r52_bit5", R52, 5);
        lines(46);
        chk("r52_51", R52, 51);
        line(64, 14, 14, 0, 8'h00, 1, 1);
        chk("ack_on_wrap_int", INT, 1);
        chk("ack_on_wrap_r52", R52, 0);

        idle(1, 8'h81, 0);
        chk("mode_pending", MODE, 0);
        chk("mode_wr_keeps_int", INT, 1);
        lines(1);
        chk("mode_1", MODE, 1);
        idle(1, 8'h92, 0);
        chk("wr92_int", INT, 0);
        chk("wr92_r52", R52, 0);
        chk("wr92_mode_old", MODE, 1);
        lines(1);
        chk("wr92_mode_new", MODE, 2);
        line(64, 3, -1, 0, 8'h00, 0, 1);
        chk("mon_hs_width3", mh_cap[15:0], 16'h0004);

        lines(38);
        chk("r52_40", R52, 40);
        vs_lvl = 1;
        mv_cap = '0;
        for (int k = 0; k < 8; k++) begin
            lines(1);
            mv_cap[k] = MON_VSYNC;
            if (k == 1) begin
                chk("resync_high_int", INT, 1);
                chk("resync_high_r52", R52, 0);
            end
        end
        chk("mon_vs_window", mv_cap, 8'b0001_1110);
        lines(8);
        vs_lvl = 0;
        lines(1);

        idle(1, 8'h90, 0);
        lines(10);
        chk("r52_10", R52, 10);
        vs_lvl = 1;
        lines(2);
        chk("resync_low_int", INT, 0);
        chk("resync_low_r52", R52, 0);
        lines(1);
        chk("mon_vs_before_rst", MON_VSYNC, 1);
        clk1(1, 0, 0, 1, 0, 8'h00, 0);
        chk("midframe_reset", {INT, MON_HSYNC, MON_VSYNC, MODE, R52}, 0);

        vs_lvl   = 0;
        side_rnd = 1;
        for (int i = 0; i < 40; i++) begin
            int p, w, et;
            p  = $urandom_range(70, 24);
            w  = $urandom_range(20, 1);
            et = $urandom_range(p - 1, 0);
            if ($urandom % 6 == 0) vs_lvl = ~vs_lvl;
            if ($urandom % 30 == 0) clk1(1, 0, 0, vs_lvl, 0, 8'h00, 0);
            line(p, w, et, ($urandom % 3 == 0), 8'($urandom),
                 ($urandom % 3 == 0), 2);
        end

        chk("queue_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
